// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package arm_pkg;

   // Access sequencer states: idle, low half-word, high half-word, completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

   // SRAM word index of a byte address: offset from the base, modulo 2^32,
   // with the byte-lane bits dropped and the result truncated to 17 bits.
   function automatic logic [SRAM_ADDR_W-2:0] word_addr(input logic [31:0] byte_addr,
                                                        input logic [31:0] base);
      return (SRAM_ADDR_W-1)'((byte_addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_half_access.sv
// Timing for one half-word SRAM access: cycle counter, end-of-half flag and
// the registered write strobe. Shared by the low and high halves.
module sram_half_access
   import arm_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
)
(
   input  logic clk,
   input  logic rst,
   input  logic active,       // a half-word access occupies the current cycle
   input  logic active_next,  // a half-word access occupies the next cycle
   input  logic store,        // the access is a write
   output logic last,         // current cycle is the final one of this half
   output logic we_n          // registered, active-low SRAM write enable
);

   localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   assign last = active && (count_reg == LAST_COUNT);

   // Count within a half; wrap to zero on its final cycle or when not accessing.
   always_comb begin
      count_next = '0;
      if (active && !last) begin
         count_next = count_reg + CNT_W'(1);
      end
   end

   // Register the counter and look ahead one cycle so WE_N is glitch-free;
   // the final cycle of each half keeps WE_N high to hold address and data.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         we_n      <= 1'b1;
      end else begin
         count_reg <= count_next;
         we_n      <= !(active_next && store && (count_next < LAST_COUNT));
      end
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage responder: turns a 32-bit load/store from the EXE->MEM register
// into two half-word accesses on a 16-bit asynchronous SRAM and freezes the
// pipeline (ready=0) until the access completes.
module mem_stage_sram_ctrl
   import arm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 2   // must be at least 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   writeBackEnIn,
   input  logic                   memReadIn,
   input  logic                   memWriteIn,
   input  logic [31:0]            ALUResultIn,
   input  logic [31:0]            reg2ValIn,
   input  logic [3:0]             destinationIn,
   output logic                   ready,
   output logic                   writeBackEn,
   output logic                   memRead,
   output logic [31:0]            ALUResult,
   output logic [3:0]             destination,
   output logic [31:0]            memResult,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
   output logic                   SRAM_DQ_oe,
   input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in
);

   state_t                 state_reg;
   state_t                 state_next;
   logic                   is_mem;
   logic                   is_store;
   logic                   is_load;
   logic [SRAM_ADDR_W-2:0] waddr;
   logic                   active;
   logic                   active_next;
   logic                   half_last;
   logic                   half_we_n;
   logic [31:0]            mem_result_reg;
   logic [SRAM_ADDR_W-1:0] sram_addr_reg;
   logic [SRAM_DATA_W-1:0] sram_dq_out_reg;
   logic                   sram_dq_oe_reg;

   // A write request wins when both strobes are set.
   assign is_mem   = memReadIn | memWriteIn;
   assign is_store = memWriteIn;
   assign is_load  = memReadIn & ~memWriteIn;
   assign waddr    = word_addr(ALUResultIn, BASE_ADDR);

   assign writeBackEn = writeBackEnIn;
   assign memRead     = memReadIn;
   assign ALUResult   = ALUResultIn;
   assign destination = destinationIn;

   assign ready       = ((state_reg == IDLE) && !is_mem) || (state_reg == DONE);
   assign active      = (state_reg == LOW) || (state_reg == HIGH);
   assign active_next = (state_next == LOW) || (state_next == HIGH);

   assign memResult   = mem_result_reg;
   assign SRAM_ADDR   = sram_addr_reg;
   assign SRAM_WE_N   = half_we_n;
   assign SRAM_DQ_out = sram_dq_out_reg;
   assign SRAM_DQ_oe  = sram_dq_oe_reg;

   sram_half_access #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_half (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .active_next(active_next),
      .store      (is_store),
      .last       (half_last),
      .we_n       (half_we_n)
   );

   // Next-state selection: each half ends when the shared counter expires.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (is_mem)    state_next = LOW;
         LOW:     if (half_last) state_next = HIGH;
         HIGH:    if (half_last) state_next = DONE;
         DONE:                   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Sequencer state plus registered SRAM address/data/drive and load capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         mem_result_reg  <= '0;
         sram_addr_reg   <= '0;
         sram_dq_out_reg <= '0;
         sram_dq_oe_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;

         if ((state_reg == IDLE) && (state_next == LOW)) begin
            sram_addr_reg   <= {waddr, 1'b0};
            sram_dq_out_reg <= reg2ValIn[15:0];
            sram_dq_oe_reg  <= is_store;
         end else if ((state_reg == LOW) && (state_next == HIGH)) begin
            sram_addr_reg   <= {waddr, 1'b1};
            sram_dq_out_reg <= reg2ValIn[31:16];
         end else if (!active_next) begin
            sram_dq_oe_reg  <= 1'b0;
         end

         // Sample read data on the final cycle of each half, when it has settled.
         if (is_load && half_last) begin
            if (state_reg == LOW) begin
               mem_result_reg[15:0] <= SRAM_DQ_in;
            end else begin
               mem_result_reg[31:16] <= SRAM_DQ_in;
            end
         end
      end
   end

endmodule
